dram_slot_arbiter: RTL and testbench

Shares the single DRAM port between video fetch, CPU, DMA and refresh using the four 7 MHz phase strobes from the 28 MHz clock block. Each 4-clock period (one slot) carries at most one DRAM access. The arbiter picks the slot owner, latches that owner's address and data, drives the DRAM controller request lines, and returns one completion strobe per granted access. It sits between the clock block and the DRAM controller in the memory subsystem.

---
 rtl/dram_arb_pkg.sv | 13 +
 rtl/dram_slot_arbiter_rfsh_timer.sv | 39 +++
 rtl/dram_slot_arbiter.sv | 115 +++++++++++
 tb/tb_dram_slot_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared owner encoding and default sizes for the DRAM slot arbiter
// No ports; imported by dram_slot_arbiter and rfsh_timer.
package dram_arb_pkg;
    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_VID  = 3'd1,
        OWN_CPU  = 3'd2,
        OWN_DMA  = 3'd3,
        OWN_RFSH = 3'd4
    } owner_e;
    localparam int ADDR_W_DEF   = 21;
    localparam int RFSH_DIV_DEF = 109;
endpackage

// File: rtl/dram_slot_arbiter_rfsh_timer.sv
// rfsh_timer: counts slots and raises pending/urgent refresh flags
// Ports: clk, rst_n (async active-low), c0 (slot strobe), grant_rfsh (refresh granted
// at this c0 edge) -> rfsh_pend (one refresh owed), rfsh_urg (two refreshes owed).
module rfsh_timer
    import dram_arb_pkg::*;
#(
    parameter int RFSH_DIV = RFSH_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic c0,
    input  logic grant_rfsh,
    output logic rfsh_pend,
    output logic rfsh_urg
);
    localparam int CW = $clog2(RFSH_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d, urg_q, urg_d, wrap;
    // A grant consumes the old flags; a wrap on the same edge re-arms pending.
    always_comb begin
        wrap   = c0 && cnt_q == CW'(RFSH_DIV - 1);
        cnt_d  = !c0 ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        pend_d = grant_rfsh ? wrap : pend_q | wrap;
        urg_d  = grant_rfsh ? 1'b0 : urg_q | (wrap & pend_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            urg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            urg_q  <= urg_d;
        end
    end
    assign rfsh_pend = pend_q;
    assign rfsh_urg  = urg_q;
endmodule

// File: rtl/dram_slot_arbiter.sv
// dram_slot_arbiter: per-slot owner selection for the shared DRAM port (video, CPU, DMA, refresh)
// Ports: clk, rst_n (async active-low); c0/c2/c3 phase strobes; vid/cpu/dma request,
// address, rnw and write data; *_strb completion pulses and rdata back to requesters;
// dram_req/rnw/rfsh/addr/wdata to the DRAM controller, dram_rdata from it.
// Define ZXEVO_DMA_EN to enable the DMA port and CPU/DMA round-robin; otherwise DMA
// inputs are ignored, dma_strb is 0 and CPU always wins the low-priority arbitration.
module dram_slot_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RFSH_DIV = RFSH_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0,
    input  logic              c2,
    input  logic              c3,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              cpu_rnw,
    input  logic              dma_rnw,
    input  logic [15:0]       cpu_wdata,
    input  logic [15:0]       dma_wdata,
    output logic              vid_strb,
    output logic              cpu_strb,
    output logic              dma_strb,
    output logic [15:0]       rdata,
    output logic              dram_req,
    output logic              dram_rnw,
    output logic              dram_rfsh,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [15:0]       dram_wdata,
    input  logic [15:0]       dram_rdata
);
    owner_e            owner_q, owner_d, win;
    logic              req_q, req_d, rnw_q, rnw_d, rfsh_q, rfsh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rfsh_pend, rfsh_urg, dma_on, cpu_first;

    rfsh_timer #(.RFSH_DIV(RFSH_DIV)) u_rfsh (
        .clk       (clk),
        .rst_n     (rst_n),
        .c0        (c0),
        .grant_rfsh(c0 && win == OWN_RFSH),
        .rfsh_pend (rfsh_pend),
        .rfsh_urg  (rfsh_urg)
    );

`ifdef ZXEVO_DMA_EN
    logic rr_q, rr_d;  // 1 = DMA favoured on the next CPU/DMA tie
    assign dma_on    = dma_req;
    assign cpu_first = !rr_q;
    assign rr_d      = (c0 && (win == OWN_CPU || win == OWN_DMA)) ? win == OWN_CPU : rr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
    assign dma_strb = (owner_q == OWN_DMA) & c3;
`else
    logic dma_unused;
    assign dma_unused = dma_req;
    assign dma_on     = 1'b0;
    assign cpu_first  = 1'b1;
    assign dma_strb   = 1'b0;
`endif

    // Refresh address is don't-care, so addr/wdata hold through RFSH and idle slots.
    always_comb begin
        win     = rfsh_urg ? OWN_RFSH : vid_req ? OWN_VID : rfsh_pend ? OWN_RFSH :
                  (cpu_req && (cpu_first || !dma_on)) ? OWN_CPU : dma_on ? OWN_DMA : OWN_NONE;
        owner_d = c0 ? win : owner_q;
        req_d   = c0 ? win != OWN_NONE : req_q;
        rfsh_d  = c0 ? win == OWN_RFSH : rfsh_q;
        addr_d  = !c0 ? addr_q : win == OWN_VID ? vid_addr : win == OWN_CPU ? cpu_addr :
                  win == OWN_DMA ? dma_addr : addr_q;
        wdata_d = !c0 ? wdata_q : win == OWN_CPU ? cpu_wdata : win == OWN_DMA ? dma_wdata : wdata_q;
        rnw_d   = (!c0 || win == OWN_NONE) ? rnw_q : win == OWN_CPU ? cpu_rnw :
                  win == OWN_DMA ? dma_rnw : 1'b1;
        rdata_d = (c2 && req_q && rnw_q && !rfsh_q) ? dram_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            rfsh_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            req_q   <= req_d;
            rnw_q   <= rnw_d;
            rfsh_q  <= rfsh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign vid_strb   = (owner_q == OWN_VID) & c3;
    assign cpu_strb   = (owner_q == OWN_CPU) & c3;
    assign rdata      = rdata_q;
    assign dram_req   = req_q;
    assign dram_rnw   = rnw_q;
    assign dram_rfsh  = rfsh_q;
    assign dram_addr  = addr_q;
    assign dram_wdata = wdata_q;
endmodule

// File: tb/tb_dram_slot_arbiter.sv
// tb_dram_slot_arbiter: randomized slot-level reference model check of dram_slot_arbiter
module tb_dram_slot_arbiter;
    localparam int ADDR_W   = 21;
    localparam int RFSH_DIV = 109;

    logic              clk = 0, rst_n = 0, c0 = 0, c2 = 0, c3 = 0;
    logic              vid_req = 0, cpu_req = 0, dma_req = 0, cpu_rnw = 0, dma_rnw = 0;
    logic [ADDR_W-1:0] vid_addr = 0, cpu_addr = 0, dma_addr = 0;
    logic [15:0]       cpu_wdata = 0, dma_wdata = 0, dram_rdata = 0;
    logic              vid_strb, cpu_strb, dma_strb, dram_req, dram_rnw, dram_rfsh;
    logic [15:0]       rdata, dram_wdata;
    logic [ADDR_W-1:0] dram_addr;

    dram_slot_arbiter #(.ADDR_W(ADDR_W), .RFSH_DIV(RFSH_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .c0(c0), .c2(c2), .c3(c3),
        .vid_req(vid_req), .cpu_req(cpu_req), .dma_req(dma_req),
        .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
        .cpu_rnw(cpu_rnw), .dma_rnw(dma_rnw), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
        .vid_strb(vid_strb), .cpu_strb(cpu_strb), .dma_strb(dma_strb), .rdata(rdata),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_rfsh(dram_rfsh),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, ph = 0;
    int rfsh_clks, cpu_cnt, dma_cnt;
    // Reference model: refreshes owed (saturating at 2), round-robin preference,
    // and the values the DRAM-side outputs should currently hold.
    int                owed, nedges;
    bit                favor_dma, m_rnw;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_wdata, m_rdata;

    task automatic model_reset();
        owed = 0; nedges = 0; favor_dma = 0; m_rnw = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    // Advance one clk; stall holds all phase strobes low without advancing the phase.
    task automatic step(input bit stall);
        @(posedge clk);
        #1;
        if (!stall) ph = (ph + 1) % 4;
        c0 = !stall && ph == 0;
        c2 = !stall && ph == 2;
        c3 = !stall && ph == 3;
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic set_random();
        vid_req   = $urandom_range(0, 3) == 0;
        cpu_req   = $urandom_range(0, 1) == 1;
        dma_req   = $urandom_range(0, 1) == 1;
        cpu_rnw   = $urandom_range(0, 1) == 1;
        dma_rnw   = $urandom_range(0, 1) == 1;
        vid_addr  = ADDR_W'($urandom);
        cpu_addr  = ADDR_W'($urandom);
        dma_addr  = ADDR_W'($urandom);
        cpu_wdata = 16'($urandom);
        dma_wdata = 16'($urandom);
    endtask

    // Entered in a c0 clk with requests set; returns in the next slot's c0 clk.
    task automatic run_slot(input int stall, input logic [15:0] rdv);
        int  e_own;
        bit  d_on, rd_slot;
`ifdef ZXEVO_DMA_EN
        d_on = dma_req;
`else
        d_on = 0;
`endif
        if (owed >= 2) e_own = 4;
        else if (vid_req) e_own = 1;
        else if (owed >= 1) e_own = 4;
        else if (cpu_req && (!d_on || !favor_dma)) e_own = 2;
        else if (d_on) e_own = 3;
        else e_own = 0;
        case (e_own)
            1: begin m_addr = vid_addr; m_rnw = 1; end
            2: begin m_addr = cpu_addr; m_rnw = cpu_rnw; m_wdata = cpu_wdata; favor_dma = 1; end
            3: begin m_addr = dma_addr; m_rnw = dma_rnw; m_wdata = dma_wdata; favor_dma = 0; end
            4: begin m_rnw = 1; owed = 0; end
            default: ;
        endcase
        rd_slot = e_own >= 1 && e_own <= 3 && m_rnw;
        nedges++;
        if (nedges % RFSH_DIV == 0) owed = owed < 2 ? owed + 1 : 2;
        step(0);
        rfsh_clks += dram_rfsh;
        n_chk++;
        if ({dram_req, dram_rfsh, dram_rnw, dram_addr, dram_wdata} !== {e_own != 0, e_own == 4, m_rnw, m_addr, m_wdata})
            $display("FAIL slot_c1 edge=%0d owner=%0d: req/rfsh/rnw/addr/wdata got %b/%b/%b/%h/%h exp %b/%b/%b/%h/%h",
                     nedges, e_own, dram_req, dram_rfsh, dram_rnw, dram_addr, dram_wdata,
                     e_own != 0, e_own == 4, m_rnw, m_addr, m_wdata);
        else n_pass++;
        n_chk++;
        if ({vid_strb, cpu_strb, dma_strb} !== 3'b000)
            $display("FAIL strb_c1 edge=%0d: strobes got %b exp 000", nedges, {vid_strb, cpu_strb, dma_strb});
        else n_pass++;
        repeat (stall) begin
            step(1);
            n_chk++;
            if ({dram_req, dram_addr, vid_strb, cpu_strb, dma_strb} !== {e_own != 0, m_addr, 3'b000})
                $display("FAIL hold edge=%0d: req/addr/strb got %b/%h/%b exp %b/%h/000",
                         nedges, dram_req, dram_addr, {vid_strb, cpu_strb, dma_strb}, e_own != 0, m_addr);
            else n_pass++;
        end
        step(0);
        dram_rdata = rdv;
        rfsh_clks += dram_rfsh;
        step(0);
        if (rd_slot) m_rdata = rdv;
        rfsh_clks += dram_rfsh;
        cpu_cnt += cpu_strb;
        dma_cnt += dma_strb;
        n_chk++;
        if ({vid_strb, cpu_strb, dma_strb, rdata} !== {e_own == 1, e_own == 2, e_own == 3, m_rdata})
            $display("FAIL slot_c3 edge=%0d owner=%0d: vid/cpu/dma strb, rdata got %b/%h exp %b/%h",
                     nedges, e_own, {vid_strb, cpu_strb, dma_strb}, rdata,
                     {e_own == 1, e_own == 2, e_own == 3}, m_rdata);
        else n_pass++;
        step(0);
        rfsh_clks += dram_rfsh;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({dram_req, dram_rnw, dram_rfsh, dram_addr, dram_wdata, rdata, vid_strb, cpu_strb, dma_strb} !== '0)
            $display("FAIL reset_outputs: req/rnw/rfsh/addr/wdata/rdata/strb got %b/%b/%b/%h/%h/%h/%b exp all 0",
                     dram_req, dram_rnw, dram_rfsh, dram_addr, dram_wdata, rdata, {vid_strb, cpu_strb, dma_strb});
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        do_reset();
        {vid_req, dma_req} = 2'b00;
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h01234;
        cpu_cnt = 0;
        run_slot(0, 16'hBEEF);
        cpu_req = 0;
        n_chk++;
        if (rdata !== 16'hBEEF || cpu_cnt != 1)
            $display("FAIL cpu_read: rdata/strobe count got %h/%0d exp beef/1", rdata, cpu_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        vid_req = 0; cpu_req = 1; dma_req = 1;
        cpu_cnt = 0; dma_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = ADDR_W'($urandom); dma_addr = ADDR_W'($urandom);
            cpu_rnw = $urandom_range(0, 1) == 1; dma_rnw = $urandom_range(0, 1) == 1;
            cpu_wdata = 16'($urandom); dma_wdata = 16'($urandom);
            run_slot(0, 16'($urandom));
        end
        n_chk++;
`ifdef ZXEVO_DMA_EN
        if (cpu_cnt != 2 || dma_cnt != 2)
            $display("FAIL round_robin: cpu/dma strobes got %0d/%0d exp 2/2", cpu_cnt, dma_cnt);
`else
        if (cpu_cnt != 4 || dma_cnt != 0)
            $display("FAIL cpu_only: cpu/dma strobes got %0d/%0d exp 4/0", cpu_cnt, dma_cnt);
`endif
        else n_pass++;
    endtask

    task automatic test_vid_starve();
        do_reset();
        vid_req = 1; cpu_req = 1; dma_req = 0; cpu_rnw = 1;
        rfsh_clks = 0; cpu_cnt = 0;
        repeat (2 * RFSH_DIV + 2) begin
            vid_addr = ADDR_W'($urandom);
            run_slot(0, 16'($urandom));
        end
        n_chk++;
        if (rfsh_clks != 4 || cpu_cnt != 0)
            $display("FAIL vid_starve: rfsh clks/cpu strobes got %0d/%0d exp 4/0", rfsh_clks, cpu_cnt);
        else n_pass++;
    endtask

    task automatic test_idle_refresh();
        do_reset();
        {vid_req, cpu_req, dma_req} = 3'b000;
        rfsh_clks = 0;
        repeat (2 * RFSH_DIV + 2) run_slot(0, 16'($urandom));
        n_chk++;
        if (rfsh_clks != 8)
            $display("FAIL idle_refresh: rfsh clks got %0d exp 8", rfsh_clks);
        else n_pass++;
    endtask

    task automatic test_random();
        repeat (150) begin
            set_random();
            run_slot($urandom_range(0, 7) == 0 ? 3 : 0, 16'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vid_req = 0;
`ifdef ZXEVO_DMA_EN
        cpu_req = 0; dma_req = 1; dma_rnw = 0; dma_addr = 21'h1ABCD; dma_wdata = 16'h5A5A;
`else
        cpu_req = 1; dma_req = 0; cpu_rnw = 0; cpu_addr = 21'h1ABCD; cpu_wdata = 16'h5A5A;
`endif
        step(0);
        n_chk++;
        if (dram_req !== 1'b1 || dram_addr !== 21'h1ABCD)
            $display("FAIL mid_pre: req/addr got %b/%h exp 1/1abcd", dram_req, dram_addr);
        else n_pass++;
        step(0);
        rst_n = 0;
        #1;
        n_chk++;
        if ({dram_req, dram_rnw, dram_rfsh, dram_addr, dram_wdata, rdata, vid_strb, cpu_strb, dma_strb} !== '0)
            $display("FAIL mid_reset: req/rnw/rfsh/addr/wdata/rdata/strb got %b/%b/%b/%h/%h/%h/%b exp all 0",
                     dram_req, dram_rnw, dram_rfsh, dram_addr, dram_wdata, rdata, {vid_strb, cpu_strb, dma_strb});
        else n_pass++;
        step(0);
        n_chk++;
        if ({vid_strb, cpu_strb, dma_strb} !== 3'b000)
            $display("FAIL mid_strb: strobes got %b exp 000", {vid_strb, cpu_strb, dma_strb});
        else n_pass++;
        rst_n = 1;
        model_reset();
        cpu_req = 1; dma_req = 1; cpu_rnw = 1; cpu_addr = 21'h00777;
        step(0);
        cpu_cnt = 0;
        run_slot(0, 16'h1357);
        n_chk++;
        if (cpu_cnt != 1)
            $display("FAIL mid_regrant: cpu strobes got %0d exp 1", cpu_cnt);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        rfsh_clks = 0; cpu_cnt = 0; dma_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        ph = 0;
        c0 = 1;
        #2;
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_vid_starve();
        test_idle_refresh();
        test_random();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
